// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: tag/value/opcode widths,
// the "no dependency" tag, opcode-class encodings and the CDB snoop helper.
package reservation_station_pkg;

  localparam int TAG_W = 4;
  localparam int VAL_W = 32;
  localparam int OP_W  = 6;

  localparam logic [TAG_W-1:0] TAG_NONE = 4'd0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 6'd0,
    OP_ALU_R  = 6'd1,
    OP_ALU_I  = 6'd2,
    OP_BRANCH = 6'd3,
    OP_LOAD   = 6'd4,
    OP_STORE  = 6'd5
  } op_class_e;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [VAL_W-1:0] vj;
    logic [VAL_W-1:0] vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [VAL_W-1:0] a;
    logic [TAG_W-1:0] dest;
    logic [VAL_W-1:0] pc;
  } rs_entry_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] val;
  } operand_t;

  typedef struct packed {
    logic             en;
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] data;
  } cdb_t;

  // A pending operand captures the first matching broadcast; the ALU bus wins ties.
  function automatic operand_t snoop_operand(operand_t opnd, cdb_t alu, cdb_t lsb);
    operand_t res;
    res = opnd;
    if ((opnd.tag != TAG_NONE) && alu.en && (alu.tag == opnd.tag)) begin
      res.tag = TAG_NONE;
      res.val = alu.data;
    end else if ((opnd.tag != TAG_NONE) && lsb.en && (lsb.tag == opnd.tag)) begin
      res.tag = TAG_NONE;
      res.val = lsb.data;
    end else begin
      res = opnd;
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// rs_select: lowest-index priority encoder with a found flag.
module rs_select #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IDX_W = $clog2(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = {IDX_W{1'b0}};
    found = |req;
    for (int i = N - 1; i >= 0; i--) begin
      idx = req[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: in-order-free dispatch, CDB wakeup, lowest-index issue.
// Optional macro RS_LSB_CDB_EN enables snooping of the load/store CDB.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear_in,
  input  logic             rs_en_in,
  input  logic [OP_W-1:0]  inst_type_in,
  input  logic [VAL_W-1:0] vj_in,
  input  logic [VAL_W-1:0] vk_in,
  input  logic [TAG_W-1:0] qj_in,
  input  logic [TAG_W-1:0] qk_in,
  input  logic [VAL_W-1:0] A_in,
  input  logic [TAG_W-1:0] dest_in,
  input  logic [VAL_W-1:0] pc_in,
  input  logic             alu_cdb_en_in,
  input  logic [TAG_W-1:0] alu_cdb_robnum_in,
  input  logic [VAL_W-1:0] alu_cdb_data_in,
  input  logic             lsb_cdb_en_in,
  input  logic [TAG_W-1:0] lsb_cdb_robnum_in,
  input  logic [VAL_W-1:0] lsb_cdb_data_in,
  output logic             rs_full_out,
  output logic             alu_en_out,
  output logic [OP_W-1:0]  alu_inst_type_out,
  output logic [VAL_W-1:0] alu_vj_out,
  output logic [VAL_W-1:0] alu_vk_out,
  output logic [VAL_W-1:0] alu_A_out,
  output logic [VAL_W-1:0] alu_pc_out,
  output logic [TAG_W-1:0] alu_dest_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t        entries_r   [DEPTH];
  rs_entry_t        entries_n_s [DEPTH];
  rs_entry_t        new_entry_s;
  rs_entry_t        issue_s;
  cdb_t             alu_cdb_s;
  cdb_t             lsb_cdb_s;
  logic [DEPTH-1:0] free_req_s;
  logic [DEPTH-1:0] ready_req_s;
  logic [IDX_W-1:0] free_idx_s;
  logic [IDX_W-1:0] ready_idx_s;
  logic             free_found_s;
  logic             ready_found_s;
  logic [CNT_W-1:0] occ_n_s;
  logic             full_n_s;

  assign alu_cdb_s = '{en: alu_cdb_en_in, tag: alu_cdb_robnum_in, data: alu_cdb_data_in};

`ifdef RS_LSB_CDB_EN
  assign lsb_cdb_s = '{en: lsb_cdb_en_in, tag: lsb_cdb_robnum_in, data: lsb_cdb_data_in};
`else
  logic unused_lsb_s;
  assign lsb_cdb_s    = '{en: 1'b0, tag: TAG_NONE, data: 32'd0};
  assign unused_lsb_s = ^{lsb_cdb_en_in, lsb_cdb_robnum_in, lsb_cdb_data_in};
`endif

  // Request vectors for the free-slot and ready-slot encoders.
  always_comb begin
    free_req_s  = '0;
    ready_req_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_req_s[i]  = ~entries_r[i].busy;
      ready_req_s[i] = entries_r[i].busy & (entries_r[i].qj == TAG_NONE)
                       & (entries_r[i].qk == TAG_NONE);
    end
  end

  rs_select #(.N(DEPTH)) u_free_sel (
    .req   (free_req_s),
    .idx   (free_idx_s),
    .found (free_found_s)
  );

  rs_select #(.N(DEPTH)) u_ready_sel (
    .req   (ready_req_s),
    .idx   (ready_idx_s),
    .found (ready_found_s)
  );

  // Next entry state: wakeup, issue release, allocation, then occupancy.
  always_comb begin
    operand_t wake_j_s;
    operand_t wake_k_s;
    entries_n_s = entries_r;
    issue_s     = entries_r[ready_idx_s];
    occ_n_s     = '0;

    for (int i = 0; i < DEPTH; i++) begin
      wake_j_s = snoop_operand('{tag: entries_r[i].qj, val: entries_r[i].vj}, alu_cdb_s, lsb_cdb_s);
      wake_k_s = snoop_operand('{tag: entries_r[i].qk, val: entries_r[i].vk}, alu_cdb_s, lsb_cdb_s);
      entries_n_s[i].qj = wake_j_s.tag;
      entries_n_s[i].vj = wake_j_s.val;
      entries_n_s[i].qk = wake_k_s.tag;
      entries_n_s[i].vk = wake_k_s.val;
    end

    // The issuing slot only becomes free for allocation next cycle.
    entries_n_s[ready_idx_s].busy = entries_r[ready_idx_s].busy & ~ready_found_s;

    wake_j_s = snoop_operand('{tag: qj_in, val: vj_in}, alu_cdb_s, lsb_cdb_s);
    wake_k_s = snoop_operand('{tag: qk_in, val: vk_in}, alu_cdb_s, lsb_cdb_s);
    new_entry_s = '{busy: 1'b1, op: inst_type_in, vj: wake_j_s.val, vk: wake_k_s.val,
                    qj: wake_j_s.tag, qk: wake_k_s.tag, a: A_in, dest: dest_in, pc: pc_in};
    entries_n_s[free_idx_s] = (rs_en_in && free_found_s) ? new_entry_s : entries_n_s[free_idx_s];

    for (int i = 0; i < DEPTH; i++) begin
      occ_n_s = occ_n_s + CNT_W'(entries_n_s[i].busy);
    end
    full_n_s = (occ_n_s >= CNT_W'(DEPTH - 1));
  end

  // State and issue registers; freeze holds everything, flush drops all entries.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      rs_full_out       <= 1'b0;
      alu_en_out        <= 1'b0;
      alu_inst_type_out <= 6'd0;
      alu_vj_out        <= 32'd0;
      alu_vk_out        <= 32'd0;
      alu_A_out         <= 32'd0;
      alu_pc_out        <= 32'd0;
      alu_dest_out      <= 4'd0;
    end else if (!rdy_in) begin
      rs_full_out <= rs_full_out;
    end else if (rob_clear_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i].busy <= 1'b0;
      end
      rs_full_out <= 1'b0;
      alu_en_out  <= 1'b0;
    end else begin
      entries_r   <= entries_n_s;
      rs_full_out <= full_n_s;
      alu_en_out  <= ready_found_s;
      if (ready_found_s) begin
        alu_inst_type_out <= issue_s.op;
        alu_vj_out        <= issue_s.vj;
        alu_vk_out        <= issue_s.vk;
        alu_A_out         <= issue_s.a;
        alu_pc_out        <= issue_s.pc;
        alu_dest_out      <= issue_s.dest;
      end else begin
        alu_dest_out <= alu_dest_out;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed table, corner sequences,
// and randomized traffic against a slot-level behavioural model.
module tb_reservation_station;

  localparam int N = 16;
`ifdef RS_LSB_CDB_EN
  localparam bit LSB_ON = 1'b1;
`else
  localparam bit LSB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rdy, rob_clear, rs_en;
  logic [5:0]  inst_type;
  logic [31:0] vj, vk, a_imm, pc;
  logic [3:0]  qj, qk, dest;
  logic        alu_cdb_en, lsb_cdb_en;
  logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_data, lsb_cdb_data;
  logic        rs_full_out, alu_en_out;
  logic [5:0]  alu_inst_type_out;
  logic [31:0] alu_vj_out, alu_vk_out, alu_A_out, alu_pc_out;
  logic [3:0]  alu_dest_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reservation_station #(.DEPTH(N)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob_clear_in(rob_clear), .rs_en_in(rs_en),
    .inst_type_in(inst_type), .vj_in(vj), .vk_in(vk), .qj_in(qj), .qk_in(qk), .A_in(a_imm),
    .dest_in(dest), .pc_in(pc),
    .alu_cdb_en_in(alu_cdb_en), .alu_cdb_robnum_in(alu_cdb_tag), .alu_cdb_data_in(alu_cdb_data),
    .lsb_cdb_en_in(lsb_cdb_en), .lsb_cdb_robnum_in(lsb_cdb_tag), .lsb_cdb_data_in(lsb_cdb_data),
    .rs_full_out(rs_full_out), .alu_en_out(alu_en_out), .alu_inst_type_out(alu_inst_type_out),
    .alu_vj_out(alu_vj_out), .alu_vk_out(alu_vk_out), .alu_A_out(alu_A_out),
    .alu_pc_out(alu_pc_out), .alu_dest_out(alu_dest_out)
  );

  // Reference model: one record per slot plus the expected registered outputs.
  logic        m_busy [N];
  logic [5:0]  m_op   [N];
  logic [31:0] m_vj [N], m_vk [N], m_a [N], m_pc [N];
  logic [3:0]  m_qj [N], m_qk [N], m_dest [N];
  logic        m_en = 1'b0, m_full = 1'b0;
  logic [137:0] m_out = '0;

  task automatic resolve(input logic [3:0] t, input logic [31:0] v,
                         output logic [3:0] ot, output logic [31:0] ov);
    ot = t;
    ov = v;
    if (t != 4'd0 && alu_cdb_en && t == alu_cdb_tag) begin
      ot = 4'd0; ov = alu_cdb_data;
    end else if (LSB_ON && t != 4'd0 && lsb_cdb_en && t == lsb_cdb_tag) begin
      ot = 4'd0; ov = lsb_cdb_data;
    end
  endtask

  task automatic model_step();
    int ri, fi, cnt;
    ri = -1; fi = -1; cnt = 0;
    if (rst) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_en = 1'b0; m_full = 1'b0; m_out = '0;
    end else if (!rdy) begin
      m_en = m_en;
    end else if (rob_clear) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_en = 1'b0; m_full = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ri < 0 && m_busy[i] && m_qj[i] == 4'd0 && m_qk[i] == 4'd0) ri = i;
        if (fi < 0 && !m_busy[i]) fi = i;
      end
      m_en = (ri >= 0);
      if (ri >= 0) begin
        m_out = {m_op[ri], m_vj[ri], m_vk[ri], m_a[ri], m_pc[ri], m_dest[ri]};
        m_busy[ri] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        resolve(m_qj[i], m_vj[i], m_qj[i], m_vj[i]);
        resolve(m_qk[i], m_vk[i], m_qk[i], m_vk[i]);
      end
      if (rs_en && fi >= 0) begin
        m_busy[fi] = 1'b1; m_op[fi] = inst_type; m_a[fi] = a_imm;
        m_pc[fi] = pc; m_dest[fi] = dest;
        resolve(qj, vj, m_qj[fi], m_vj[fi]);
        resolve(qk, vk, m_qk[fi], m_vk[fi]);
      end
      for (int i = 0; i < N; i++) cnt += int'(m_busy[i]);
      m_full = (cnt >= N - 1);
    end
  endtask

  task automatic check(input string name, input logic [137:0] got, input logic [137:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_en", alu_en_out, m_en);
    check("model_full", rs_full_out, m_full);
    check("model_payload", {alu_inst_type_out, alu_vj_out, alu_vk_out, alu_A_out,
                            alu_pc_out, alu_dest_out}, m_out);
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; rob_clear = 1'b0; rs_en = 1'b0;
    alu_cdb_en = 1'b0; lsb_cdb_en = 1'b0;
    qj = 4'd0; qk = 4'd0;
  endtask

  task automatic disp(input logic [31:0] dvj, input logic [31:0] dvk,
                      input logic [3:0] dqj, input logic [3:0] dqk, input logic [3:0] ddest);
    rs_en = 1'b1; vj = dvj; vk = dvk; qj = dqj; qk = dqk; dest = ddest;
    inst_type = 6'(ddest) + 6'd1; a_imm = {28'd0, ddest}; pc = 32'h1000 + {28'd0, ddest};
  endtask

  typedef struct {
    logic en; logic [31:0] vj, vk; logic [3:0] qj, qk, dest;
    logic cdb; logic [3:0] tag; logic [31:0] data; logic lsb; logic [31:0] ldata;
    logic exp_en; logic [31:0] exp_vj, exp_vk; logic [3:0] exp_dest;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[1]  = '{1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd5, 32'd7, 4'd3};
    tbl[2]  = '{1'b1, 32'd0, 32'd1, 4'd2, 4'd0, 4'd4, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[3]  = '{1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 32'h10, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[4]  = '{1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h10, 32'd1, 4'd4};
    tbl[5]  = '{1'b1, 32'd9, 32'd0, 4'd0, 4'd4, 4'd5, 1'b1, 4'd4, 32'hAB, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[6]  = '{1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd9, 32'hAB, 4'd5};
    tbl[7]  = '{1'b1, 32'd0, 32'd3, 4'd7, 4'd0, 4'd7, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[8]  = '{1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd7, 32'h77, 1'b1, 32'h88, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[9]  = '{1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h77, 32'd3, 4'd7};
    tbl[10] = '{1'b1, 32'd1, 32'd1, 4'd0, 4'd0, 4'd8, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[11] = '{1'b1, 32'd2, 32'd2, 4'd0, 4'd0, 4'd9, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd1, 32'd1, 4'd8};
    tbl[12] = '{1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd2, 32'd2, 4'd9};
    tbl[13] = '{1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0};

    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0; m_op[i] = '0; m_vj[i] = '0; m_vk[i] = '0; m_a[i] = '0;
      m_pc[i] = '0; m_qj[i] = '0; m_qk[i] = '0; m_dest[i] = '0;
    end
    inst_type = 6'd0; vj = 32'd0; vk = 32'd0; a_imm = 32'd0; pc = 32'd0; dest = 4'd0;
    alu_cdb_tag = 4'd0; alu_cdb_data = 32'd0; lsb_cdb_tag = 4'd0; lsb_cdb_data = 32'd0;

    // Reset state
    idle(); rst = 1'b1; rdy = 1'b0;
    tick();
    check("reset_en", alu_en_out, 1'b0);
    check("reset_full", rs_full_out, 1'b0);
    check("reset_payload", {alu_inst_type_out, alu_vj_out, alu_vk_out, alu_A_out, alu_pc_out, alu_dest_out}, 138'd0);
    idle(); tick();

    // Directed table: basic issue, CDB wakeup, same-cycle bypass, CDB priority, alloc+issue.
    for (int r = 0; r < 14; r++) begin
      idle();
      if (tbl[r].en) disp(tbl[r].vj, tbl[r].vk, tbl[r].qj, tbl[r].qk, tbl[r].dest);
      alu_cdb_en = tbl[r].cdb; alu_cdb_tag = tbl[r].tag; alu_cdb_data = tbl[r].data;
      lsb_cdb_en = tbl[r].lsb; lsb_cdb_tag = tbl[r].tag; lsb_cdb_data = tbl[r].ldata;
      tick();
      check($sformatf("tbl%0d_en", r), alu_en_out, tbl[r].exp_en);
      if (tbl[r].exp_en)
        check($sformatf("tbl%0d_ops", r), {alu_vj_out, alu_vk_out, alu_dest_out},
              {tbl[r].exp_vj, tbl[r].exp_vk, tbl[r].exp_dest});
    end

    // Fill 15 stalled entries: full asserts only at DEPTH-1.
    for (int i = 0; i < 15; i++) begin
      idle(); disp(32'(i), 32'd0, (i == 0) ? 4'd1 : 4'd15, 4'd0, 4'(i));
      tick();
      check($sformatf("fill%0d_full", i), rs_full_out, (i == 14));
    end
    idle(); alu_cdb_en = 1'b1; alu_cdb_tag = 4'd1; alu_cdb_data = 32'h99;
    tick();
    check("wake_no_issue", alu_en_out, 1'b0);
    check("wake_full", rs_full_out, 1'b1);
    idle(); tick();
    check("drain_issue", {alu_en_out, alu_vj_out, alu_dest_out}, {1'b1, 32'h99, 4'd0});
    check("drain_full", rs_full_out, 1'b0);

    // Fill all 16, then a ready dispatch must be dropped.
    idle(); disp(32'd0, 32'd0, 4'd15, 4'd0, 4'd14); tick();
    idle(); disp(32'd0, 32'd0, 4'd15, 4'd0, 4'd15); tick();
    check("all_busy_full", rs_full_out, 1'b1);
    idle(); disp(32'd0, 32'd0, 4'd0, 4'd0, 4'd13); tick();
    idle(); tick();
    check("drop_when_full", alu_en_out, 1'b0);

    // Flush overrides dispatch and wakeup.
    idle(); disp(32'd0, 32'd0, 4'd0, 4'd0, 4'd2);
    alu_cdb_en = 1'b1; alu_cdb_tag = 4'd15; alu_cdb_data = 32'd1; rob_clear = 1'b1;
    tick();
    check("clear_en", alu_en_out, 1'b0);
    check("clear_full", rs_full_out, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_clear%0d", i), alu_en_out, 1'b0);
    end
    idle(); disp(32'd0, 32'd0, 4'd0, 4'd0, 4'd10); tick();
    idle(); rob_clear = 1'b1; tick();
    check("clear_blocks_issue", alu_en_out, 1'b0);
    idle(); tick();
    check("clear_ready_gone", alu_en_out, 1'b0);

    // Freeze for 3 cycles with a ready entry; inputs during freeze are ignored.
    idle(); disp(32'h11, 32'd0, 4'd0, 4'd0, 4'd11); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 1'b0; disp(32'h12, 32'd0, 4'd0, 4'd0, 4'd12);
      tick();
      check($sformatf("freeze%0d_en", i), alu_en_out, 1'b0);
    end
    idle(); tick();
    check("unfreeze_issue", {alu_en_out, alu_vj_out, alu_dest_out}, {1'b1, 32'h11, 4'd11});
    tick();
    check("freeze_dispatch_ignored", alu_en_out, 1'b0);

    // Reset mid-operation discards pending work, regardless of rdy.
    idle(); disp(32'h55, 32'd0, 4'd0, 4'd0, 4'd5); tick();
    idle(); rst = 1'b1; rdy = 1'b0; tick();
    check("midrst_out", {alu_en_out, rs_full_out, alu_vj_out, alu_dest_out}, 38'd0);
    idle(); tick();
    check("midrst_no_issue", alu_en_out, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      rdy       = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 79) == 0);
      rs_en     = ($urandom_range(0, 9) < 6);
      inst_type = 6'($urandom);
      vj = $urandom; vk = $urandom; a_imm = $urandom; pc = $urandom;
      dest = 4'($urandom);
      qj = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
      qk = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
      alu_cdb_en = ($urandom_range(0, 2) == 0);
      alu_cdb_tag = 4'($urandom_range(1, 4)); alu_cdb_data = $urandom;
      lsb_cdb_en = ($urandom_range(0, 2) == 0);
      lsb_cdb_tag = 4'($urandom_range(1, 4)); lsb_cdb_data = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
